// File: rtl/sico_play_stream_pkg.sv
// Shared types and constants for the co-simulation player stream stage.
package SiCoStreamPkg;

  // Filter FSM states: IDLE waits for a change, SETTLE waits for it to hold.
  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_e;

  // Dropped-value counter width and its saturation point.
  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Saturating increment for the drop counter.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] c);
    return (c == DROP_CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/sico_stream_fifo.sv
// Register-array FIFO with extra-MSB pointers to tell full from empty.
// A push while full is ignored here; the caller decides what a drop means.
module sico_stream_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic                        do_push;
  logic                        do_pop;

  // Full when indices match but wrap bits differ.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign head    = mem[rd_ptr[AW-1:0]];
  // Fullness is the pre-pop view, so a push to a full FIFO never sneaks in
  // behind a same-cycle pop.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage and pointers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/sico_play_stream.sv
// Samples an unclocked player value into clk_i, rejects transitional glitches
// and emits each settled change as one beat through a small FIFO.
// Optional feature macro: SICO_PLAY_STREAM_DROPCNT_EN builds the 16-bit
// saturating drop counter; without it drop_cnt_o is tied to zero.
module sico_play_stream
  import SiCoStreamPkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               SYNC_STAGES   = 2,
  parameter int               STABLE_CYCLES = 2,
  parameter int               DEPTH         = 4,
  parameter logic [WIDTH-1:0] RST_VAL       = {WIDTH{1'b0}}
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      val_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overflow_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  // Counter only needs to reach STABLE_CYCLES-1.
  localparam int            CW       = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  synced;

  state_e           state, state_nx;
  logic [WIDTH-1:0] last, last_nx;
  logic [WIDTH-1:0] cand, cand_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             push_req;
  logic [WIDTH-1:0] push_val;

  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;
  logic             overflow_q;

  // Synchronizer shift chain; the last flop is the only one the FSM looks at.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], val_i};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        // With single-cycle stability a change is taken straight from IDLE.
        if ((synced != last) && (STABLE_CYCLES > 1)) state_nx = SETTLE;
      end
      SETTLE: begin
        if (synced == cand) begin
          if (cnt == CNT_LAST) state_nx = IDLE;
        end else if (synced == last) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: push request and next values of last/cand/cnt.
  always_comb begin
    push_req = 1'b0;
    push_val = cand;
    last_nx  = last;
    cand_nx  = cand;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (synced != last) begin
          if (STABLE_CYCLES == 1) begin
            push_req = 1'b1;
            push_val = synced;
            last_nx  = synced;
          end else begin
            cand_nx = synced;
            cnt_nx  = CNT_ONE;
          end
        end
      end
      SETTLE: begin
        if (synced == cand) begin
          if (cnt == CNT_LAST) begin
            push_req = 1'b1;
            push_val = cand;
            // last moves even if the FIFO drops the value: no retry.
            last_nx  = cand;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end else if (synced != last) begin
          // Moved to a third value: restart settling on it.
          cand_nx = synced;
          cnt_nx  = CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  // Filter datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last <= RST_VAL;
      cand <= '0;
      cnt  <= '0;
    end else begin
      last <= last_nx;
      cand <= cand_nx;
      cnt  <= cnt_nx;
    end
  end

  sico_stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push_req),
    .wdata (push_val),
    .full  (fifo_full),
    .pop   (valid_o & ready_i),
    .empty (fifo_empty),
    .head  (data_o)
  );

  assign valid_o = ~fifo_empty;
  assign drop    = push_req & fifo_full;

  // Sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i)     overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

  assign overflow_o = overflow_q;

`ifdef SICO_PLAY_STREAM_DROPCNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt;

  // Saturating count of dropped values.
  always_ff @(posedge clk_i) begin
    if (rst_i)     drop_cnt <= '0;
    else if (drop) drop_cnt <= sat_inc(drop_cnt);
  end

  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sico_play_stream.sv
// Directed bench for sico_play_stream (WIDTH=8, other parameters default).
module tb_sico_play_stream;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  val_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sico_play_stream #(
    .WIDTH (8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .val_i      (val_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  typedef struct {
    logic [7:0] val;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[20];

`ifdef SICO_PLAY_STREAM_DROPCNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    val_i   = 8'h00;
    ready_i = 1'b0;
    rst_i   = 1'b1;
    tick();
    tick();
    rst_i   = 1'b0;
  endtask

  // Drive a new value and hold it long enough to be pushed (push on 4th edge).
  task automatic settle(input logic [7:0] v);
    val_i = v;
    repeat (5) tick();
  endtask

  task automatic drain_chk(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, {15'd0, valid_o}, 16'd1);
    chk({name, "_data"}, {8'd0, data_o}, {8'd0, exp});
    tick();
  endtask

  initial begin
    tbl[0]  = '{8'h00, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{8'h00, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{8'h5A, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{8'h5A, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{8'h5A, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{8'h5A, 1'b1, 1'b1, 8'h5A};
    tbl[6]  = '{8'h5A, 1'b1, 1'b0, 8'h00};
    tbl[7]  = '{8'h5A, 1'b1, 1'b0, 8'h00};
    tbl[8]  = '{8'h3C, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{8'h5A, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{8'h5A, 1'b1, 1'b0, 8'h00};
    tbl[11] = '{8'h5A, 1'b1, 1'b0, 8'h00};
    tbl[12] = '{8'h5A, 1'b1, 1'b0, 8'h00};
    tbl[13] = '{8'h5A, 1'b1, 1'b0, 8'h00};
    tbl[14] = '{8'h11, 1'b1, 1'b0, 8'h00};
    tbl[15] = '{8'h22, 1'b1, 1'b0, 8'h00};
    tbl[16] = '{8'h22, 1'b1, 1'b0, 8'h00};
    tbl[17] = '{8'h22, 1'b1, 1'b0, 8'h00};
    tbl[18] = '{8'h22, 1'b1, 1'b1, 8'h22};
    tbl[19] = '{8'h22, 1'b1, 1'b0, 8'h00};

    // Reset state, then a held zero never produces a beat.
    do_reset();
    chk("rst_valid", {15'd0, valid_o}, 16'd0);
    chk("rst_data", {8'd0, data_o}, 16'd0);
    chk("rst_ovf", {15'd0, overflow_o}, 16'd0);
    chk("rst_drop", drop_cnt_o, 16'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("idle_valid", {15'd0, valid_o}, 16'd0);
    end

    // Latency pulse, glitch rejection, candidate replacement.
    for (int i = 0; i < 20; i++) begin
      val_i   = tbl[i].val;
      ready_i = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), {15'd0, valid_o}, {15'd0, tbl[i].ev});
      if (tbl[i].ev) chk($sformatf("vec%0d_data", i), {8'd0, data_o}, {8'd0, tbl[i].ed});
      chk($sformatf("vec%0d_ovf", i), {15'd0, overflow_o}, 16'd0);
    end

    // Six settled changes into a 4-deep FIFO with no consumer.
    do_reset();
    settle(8'h11); settle(8'h22); settle(8'h11);
    settle(8'h22); settle(8'h11); settle(8'h22);
    repeat (3) tick();
    chk("ovf_flag", {15'd0, overflow_o}, 16'd1);
    chk("ovf_drop", drop_cnt_o, (DROP_EN != 0) ? 16'd2 : 16'd0);
    ready_i = 1'b1;
    drain_chk("ovf_d0", 8'h11);
    drain_chk("ovf_d1", 8'h22);
    drain_chk("ovf_d2", 8'h11);
    drain_chk("ovf_d3", 8'h22);
    chk("ovf_empty", {15'd0, valid_o}, 16'd0);
    chk("ovf_sticky", {15'd0, overflow_o}, 16'd1);

    // Push arrives on the same edge a full FIFO pops: dropped, occupancy 3.
    do_reset();
    settle(8'h11); settle(8'h22); settle(8'h11); settle(8'h22);
    val_i = 8'h11;
    repeat (3) tick();
    chk("full_pre_ovf", {15'd0, overflow_o}, 16'd0);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("full_ovf", {15'd0, overflow_o}, 16'd1);
    chk("full_drop", drop_cnt_o, (DROP_EN != 0) ? 16'd1 : 16'd0);
    tick();
    chk("full_head_hold", {8'd0, data_o}, 16'h0022);
    ready_i = 1'b1;
    drain_chk("full_d0", 8'h22);
    drain_chk("full_d1", 8'h11);
    drain_chk("full_d2", 8'h22);
    chk("full_empty", {15'd0, valid_o}, 16'd0);

    // Reset with 3 queued entries and a change mid-SETTLE.
    ready_i = 1'b0;
    settle(8'h22); settle(8'h11); settle(8'h22);
    val_i = 8'h33;
    repeat (3) tick();
    chk("mid_pre_valid", {15'd0, valid_o}, 16'd1);
    chk("mid_pre_head", {8'd0, data_o}, 16'h0022);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mid_valid", {15'd0, valid_o}, 16'd0);
    chk("mid_ovf", {15'd0, overflow_o}, 16'd0);
    chk("mid_data", {8'd0, data_o}, 16'd0);
    chk("mid_drop", drop_cnt_o, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_lat_valid", {15'd0, valid_o}, 16'd0);
    end
    tick();
    chk("mid_post_valid", {15'd0, valid_o}, 16'd1);
    chk("mid_post_data", {8'd0, data_o}, 16'h0033);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
